// File: rtl/serv_seq_ctrl.sv
// rtl/serv_seq_ctrl.sv - bit-serial sequencer: fetch handshake, INIT/WAIT/RUN phases, bit counter
// Optional feature macro: SERV_SEQ_MISALIGN_TRAP_EN (registered misaligned-access trap)
module serv_seq_ctrl #(
  parameter int W     = 1,
  parameter int N_EXT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ibus_ack,
  output logic             o_ibus_cyc,
  input  logic             i_rf_ready,
  output logic             o_rf_rreq,
  output logic             o_rf_wreq,
  input  logic             i_two_stage_op,
  input  logic             i_dbus_en,
  input  logic             i_mem_misalign,
  input  logic             i_dbus_ack,
  output logic             o_dbus_cyc,
  input  logic [N_EXT-1:0] i_ext_op,
  input  logic [N_EXT-1:0] i_ext_ready,
  output logic [N_EXT-1:0] o_ext_valid,
  output logic             o_init,
  output logic             o_cnt_en,
  output logic             o_cnt_done,
  output logic             o_ctrl_pc_en,
  output logic [4:0]       o_cnt,
  output logic             o_misalign_trap
);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("serv_seq_ctrl: W must be 1, 2, 4 or 8");
    end
    if (N_EXT < 1 || N_EXT > 4) begin : g_bad_n_ext
      $error("serv_seq_ctrl: N_EXT must be 1..4");
    end
  endgenerate

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  typedef enum logic [1:0] {IDLE, INIT, WAIT, RUN} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ibus_cyc_q, ibus_cyc_d;
  logic       started_q, started_d;
  logic       init_done_q, init_done_d;

  logic cnt_en, cnt_done, in_wait, dbus_req, ext_hit, ext_pending, wait_done, trap;

`ifdef SERV_SEQ_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign trap     = trap_q;
  // A trapped access never reaches the data bus.
  assign dbus_req = i_dbus_en & ~i_mem_misalign & ~trap_q;
`else
  logic unused_misalign;
  assign unused_misalign = i_mem_misalign;
  assign trap            = 1'b0;
  assign dbus_req        = i_dbus_en;
`endif

  assign cnt_en      = (state_q == INIT) || (state_q == RUN);
  assign cnt_done    = cnt_en && (cnt_q == LAST);
  assign in_wait     = (state_q == WAIT);
  // Ready from a channel that was not selected is masked off here.
  assign ext_hit     = |(i_ext_op & i_ext_ready);
  assign ext_pending = |i_ext_op;
  assign wait_done   = in_wait & ((dbus_req & i_dbus_ack) | ext_hit | trap | (~dbus_req & ~ext_pending));

  assign o_ibus_cyc      = ibus_cyc_q;
  assign o_rf_rreq       = (started_q & i_ibus_ack) | (in_wait & trap);
  assign o_rf_wreq       = wait_done;
  assign o_dbus_cyc      = in_wait & dbus_req;
  assign o_ext_valid     = in_wait ? i_ext_op : '0;
  assign o_init          = (state_q == INIT);
  assign o_cnt_en        = cnt_en;
  assign o_cnt_done      = cnt_done;
  assign o_ctrl_pc_en    = cnt_en & ~o_init;
  assign o_cnt           = cnt_q;
  assign o_misalign_trap = trap;

  // Next-state logic for phase FSM, bit counter, fetch request and trap flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_en ? cnt_q + STEP : 5'd0;
    started_d   = 1'b1;
    init_done_d = init_done_q;
    ibus_cyc_d  = ibus_cyc_q;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif
    if (!started_q) begin
      ibus_cyc_d = 1'b1;
    end else if (i_ibus_ack) begin
      ibus_cyc_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        // A fetch ack in the same cycle takes priority; counting waits a cycle.
        if (i_rf_ready && !i_ibus_ack) begin
          state_d = (i_two_stage_op && !init_done_q) ? INIT : RUN;
        end
      end
      INIT: begin
        if (cnt_done) begin
          state_d     = WAIT;
          init_done_d = 1'b1;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
          trap_d      = i_dbus_en & i_mem_misalign;
`endif
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_done) begin
          state_d     = IDLE;
          init_done_d = 1'b0;
          ibus_cyc_d  = 1'b1;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
          trap_d      = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state register; asynchronous reset aborts any phase immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      ibus_cyc_q  <= 1'b0;
      started_q   <= 1'b0;
      init_done_q <= 1'b0;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ibus_cyc_q  <= ibus_cyc_d;
      started_q   <= started_d;
      init_done_q <= init_done_d;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// tb/tb_serv_seq_ctrl.sv - directed scoreboard bench for serv_seq_ctrl (W=1 and W=4 instances)
module tb_serv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack, ready, two_stage, dbus_en, misalign, dbus_ack;
  logic [1:0] ext_op, ext_ready;
  logic       sel;

  wire [15:0] o1, o4;
  wire [15:0] ob = sel ? o4 : o1;
  wire        ibus_cyc  = ob[15];
  wire        rreq      = ob[14];
  wire        wreq      = ob[13];
  wire        dbus_cyc  = ob[12];
  wire [1:0]  ext_valid = ob[11:10];
  wire        init      = ob[9];
  wire        cnt_en    = ob[8];
  wire        cnt_done  = ob[7];
  wire        pc_en     = ob[6];
  wire [4:0]  cnt       = ob[5:1];
  wire        trap      = ob[0];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt[$];
  logic [1:0] exp_bus[$];
  int len;

  always #5 clk = ~clk;

  serv_seq_ctrl #(.W(1), .N_EXT(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ack), .o_ibus_cyc(o1[15]),
    .i_rf_ready(ready), .o_rf_rreq(o1[14]), .o_rf_wreq(o1[13]),
    .i_two_stage_op(two_stage), .i_dbus_en(dbus_en), .i_mem_misalign(misalign),
    .i_dbus_ack(dbus_ack), .o_dbus_cyc(o1[12]), .i_ext_op(ext_op),
    .i_ext_ready(ext_ready), .o_ext_valid(o1[11:10]), .o_init(o1[9]),
    .o_cnt_en(o1[8]), .o_cnt_done(o1[7]), .o_ctrl_pc_en(o1[6]),
    .o_cnt(o1[5:1]), .o_misalign_trap(o1[0])
  );

  serv_seq_ctrl #(.W(4), .N_EXT(2)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ibus_ack(ack), .o_ibus_cyc(o4[15]),
    .i_rf_ready(ready), .o_rf_rreq(o4[14]), .o_rf_wreq(o4[13]),
    .i_two_stage_op(two_stage), .i_dbus_en(dbus_en), .i_mem_misalign(misalign),
    .i_dbus_ack(dbus_ack), .o_dbus_cyc(o4[12]), .i_ext_op(ext_op),
    .i_ext_ready(ext_ready), .o_ext_valid(o4[11:10]), .o_init(o4[9]),
    .o_cnt_en(o4[8]), .o_cnt_done(o4[7]), .o_ctrl_pc_en(o4[6]),
    .o_cnt(o4[5:1]), .o_misalign_trap(o4[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in the first cycle of a phase; returns after the phase, in the following cycle.
  task automatic run_phase(input string tag, input int step, input logic exp_init, output int n);
    int e;
    for (int v = 0; v < 32; v += step) exp_cnt.push_back(v);
    n = 0;
    for (int i = 0; i < 40 && cnt_en; i++) begin
      n++;
      e = (exp_cnt.size() != 0) ? exp_cnt.pop_front() : -1;
      chk({tag, "_cnt"}, 32'(cnt), 32'(e));
      chk({tag, "_done"}, 32'(cnt_done), 32'(e == 32 - step));
      chk({tag, "_init"}, 32'(init), 32'(exp_init));
      chk({tag, "_pc_en"}, 32'(pc_en), 32'(!exp_init));
      tick();
    end
    chk({tag, "_len"}, 32'(n), 32'(32 / step));
    exp_cnt.delete();
  endtask

  task automatic fetch_and_start(input logic two);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    two_stage = two;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ack = 0; ready = 0; two_stage = 0; dbus_en = 0; misalign = 0;
    dbus_ack = 0; ext_op = 2'b00; ext_ready = 2'b00; sel = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ibus_cyc", 32'(ibus_cyc), 0);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_wreq", 32'(wreq), 0);
    chk("rst_rreq", 32'(rreq), 0);

    // W=1 single-stage: ack at cycle 3, rf_ready at cycle 5
    rst_n = 1'b1;
    tick();
    chk("boot_ibus_cyc", 32'(ibus_cyc), 1);
    tick();
    tick();
    ack = 1'b1;
    #1;
    chk("ack_rreq", 32'(rreq), 1);
    tick();
    ack = 1'b0;
    #1;
    chk("ack_drop_ibus", 32'(ibus_cyc), 0);
    chk("ack_drop_rreq", 32'(rreq), 0);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    run_phase("w1_run", 1, 1'b0, len);
    chk("w1_refetch", 32'(ibus_cyc), 1);
    chk("w1_idle", 32'(cnt_en), 0);

    // Ack and ready in the same cycle: counter must not start
    ack = 1'b1;
    ready = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    chk("same_cyc_no_start", 32'(cnt_en), 0);
    chk("same_cyc_ibus", 32'(ibus_cyc), 0);
    tick();
    ready = 1'b0;
    #1;
    chk("start_after_ack", 32'(cnt_en), 1);
    run_phase("w1_run2", 1, 1'b0, len);

    // W=4 two-stage ALU op: INIT, immediate wreq, RUN
    sel = 1'b1;
    #1;
    fetch_and_start(1'b1);
    run_phase("alu_init", 4, 1'b1, len);
    chk("alu_wreq", 32'(wreq), 1);
    chk("alu_wait_no_dbus", 32'(dbus_cyc), 0);
    tick();
    chk("alu_wreq_once", 32'(wreq), 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    run_phase("alu_run", 4, 1'b0, len);
    chk("alu_refetch", 32'(ibus_cyc), 1);

    // Load: dbus ack in the 6th WAIT cycle
    dbus_en = 1'b1;
    fetch_and_start(1'b1);
    run_phase("ld_init", 4, 1'b1, len);
    for (int i = 0; i < 6; i++) exp_bus.push_back({1'b1, 1'(i == 5)});
    exp_bus.push_back(2'b00);
    for (int i = 0; i < 7; i++) begin
      logic [1:0] e;
      dbus_ack = (i == 5);
      #1;
      e = exp_bus.pop_front();
      chk("ld_dbus_cyc", 32'(dbus_cyc), 32'(e[1]));
      chk("ld_wreq", 32'(wreq), 32'(e[0]));
      tick();
    end
    dbus_ack = 1'b0;
    dbus_en = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    run_phase("ld_run", 4, 1'b0, len);

    // Extension: ready on the unselected channel is ignored
    ext_op = 2'b10;
    fetch_and_start(1'b1);
    run_phase("ext_init", 4, 1'b1, len);
    chk("ext_valid", 32'(ext_valid), 32'h2);
    chk("ext_no_wreq", 32'(wreq), 0);
    ext_ready = 2'b01;
    #1;
    chk("ext_wrong_rdy", 32'(wreq), 0);
    chk("ext_valid_hold", 32'(ext_valid), 32'h2);
    tick();
    ext_ready = 2'b10;
    #1;
    chk("ext_right_rdy", 32'(wreq), 1);
    tick();
    ext_ready = 2'b00;
    #1;
    chk("ext_valid_drop", 32'(ext_valid), 0);
    chk("ext_wreq_drop", 32'(wreq), 0);
    ext_op = 2'b00;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    run_phase("ext_run", 4, 1'b0, len);

    // Misaligned load
    dbus_en = 1'b1;
    misalign = 1'b1;
    fetch_and_start(1'b1);
    run_phase("mis_init", 4, 1'b1, len);
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    chk("mis_no_dbus", 32'(dbus_cyc), 0);
    chk("mis_trap", 32'(trap), 1);
    chk("mis_rreq", 32'(rreq), 1);
    chk("mis_wreq", 32'(wreq), 1);
    tick();
    chk("mis_rreq_once", 32'(rreq), 0);
`else
    chk("mis_dbus", 32'(dbus_cyc), 1);
    chk("mis_trap0", 32'(trap), 0);
    chk("mis_rreq0", 32'(rreq), 0);
    chk("mis_wreq0", 32'(wreq), 0);
    dbus_ack = 1'b1;
    #1;
    chk("mis_ack_wreq", 32'(wreq), 1);
    tick();
    dbus_ack = 1'b0;
`endif
    dbus_en = 1'b0;
    misalign = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #1;
    run_phase("mis_run", 4, 1'b0, len);
    chk("mis_trap_clr", 32'(trap), 0);

    // Reset during INIT at o_cnt=12
    fetch_and_start(1'b1);
    for (int i = 0; i < 20 && !(cnt_en && cnt == 5'd12); i++) tick();
    chk("abort_reach12", 32'(cnt), 12);
    rst_n = 1'b0;
    #1;
    chk("abort_cnt", 32'(cnt), 0);
    chk("abort_cnt_en", 32'(cnt_en), 0);
    chk("abort_wreq", 32'(wreq), 0);
    chk("abort_done", 32'(cnt_done), 0);
    chk("abort_ibus", 32'(ibus_cyc), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_hold_wreq", 32'(wreq), 0);
      chk("abort_hold_cnt_en", 32'(cnt_en), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("abort_boot_ibus", 32'(ibus_cyc), 1);
    chk("abort_idle", 32'(cnt_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_seq_ctrl.md
SERV_SEQ_CTRL -- requirements
Module: serv_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 1: datapath bits per cycle; legal 1, 2, 4 or 8; other values SHALL fail elaboration.
REQ-002 SHALL have parameter N_EXT, default 2: number of extension channels (MDU, AVA, ...); legal 1..4.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_ibus_ack, input, 1: instruction fetch complete.
REQ-006 SHALL have port o_ibus_cyc, output, 1: instruction fetch request.
REQ-007 SHALL have port i_rf_ready, input, 1: register file ready; starts a counting phase.
REQ-008 SHALL have ports o_rf_rreq / o_rf_wreq, output, 1 each: RF read / write request strobes.
REQ-009 SHALL have port i_two_stage_op, input, 1: current instruction uses INIT plus RUN phases.
REQ-010 SHALL have ports i_dbus_en / i_mem_misalign / i_dbus_ack, input, 1 each: memory op, misaligned address, data bus ack.
REQ-011 SHALL have port o_dbus_cyc, output, 1: data bus request.
REQ-012 SHALL have ports i_ext_op / i_ext_ready, input, N_EXT: one-hot extension select / per-channel done.
REQ-013 SHALL have port o_ext_valid, output, N_EXT: per-channel start.
REQ-014 SHALL have ports o_init / o_cnt_en / o_cnt_done / o_ctrl_pc_en, output, 1 each: INIT phase, counter running, last count cycle, PC update enable.
REQ-015 SHALL have port o_cnt, output, 5: index of lowest bit processed this cycle (multiple of W).
REQ-016 SHALL have port o_misalign_trap, output, 1: registered misalign trap flag.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, WAIT, RUN; reset state IDLE.
REQ-018 Phase length SHALL be 32/W cycles; o_cnt SHALL step by W from 0, wrapping to 0 after 32-W.
REQ-019 o_cnt_en SHALL be high exactly during INIT and RUN; o_cnt_done high only in the cycle where o_cnt == 32-W.
REQ-020 o_ibus_cyc SHALL rise the cycle after reset release and the cycle after RUN's o_cnt_done; SHALL fall the cycle after i_ibus_ack.
REQ-021 o_rf_rreq SHALL equal i_ibus_ack, OR the first WAIT cycle when o_misalign_trap is set.
REQ-022 IDLE + i_rf_ready SHALL enter INIT if i_two_stage_op and no INIT done yet for this instruction, else RUN.
REQ-023 INIT + o_cnt_done SHALL enter WAIT; o_init high only in INIT.
REQ-024 WAIT: o_dbus_cyc = i_dbus_en & !i_mem_misalign; o_ext_valid[k] = i_ext_op[k]; both SHALL hold until the matching ack/ready.
REQ-025 WAIT: o_rf_wreq SHALL pulse one cycle on i_dbus_ack, any enabled i_ext_ready, misalign trap, or immediately when no dbus/ext op is pending; then IDLE, awaiting i_rf_ready for RUN.
REQ-026 RUN + o_cnt_done SHALL return to IDLE and clear the INIT-done flag.
REQ-027 o_ctrl_pc_en SHALL equal o_cnt_en & !o_init.
REQ-028 i_ibus_ack and i_rf_ready in the same cycle: ack handled first; the counter SHALL NOT start that cycle.
REQ-029 Ready on a channel whose i_ext_op is low SHALL be ignored.

Reset
REQ-030 While i_rst_n low: state IDLE, o_cnt 0, all outputs 0 except o_ibus_cyc; o_ibus_cyc SHALL be 0 during reset, 1 the first cycle after release.
REQ-031 Reset mid-phase SHALL abort immediately; no partial o_rf_wreq or o_cnt_done SHALL be emitted.

Configuration
REQ-032 Macro SERV_SEQ_MISALIGN_TRAP_EN defined: o_misalign_trap SHALL load (i_dbus_en & i_mem_misalign) on INIT's o_cnt_done, clear on RUN's o_cnt_done, and suppress o_dbus_cyc.
REQ-033 Macro undefined: o_misalign_trap SHALL be constant 0 with no register; misaligned accesses SHALL proceed to o_dbus_cyc.

Verification
REQ-034 Reset release, W=1, ibus ack at cycle 3, rf_ready at cycle 5, single-stage -> o_cnt_en high exactly 32 cycles, o_cnt_done at o_cnt=31, o_ibus_cyc reasserted next cycle.
REQ-035 W=4, two-stage ALU op -> INIT 8 cycles, o_cnt 0,4,..,28; o_rf_wreq one pulse; RUN 8 cycles.
REQ-036 Load, dbus ack 6 cycles into WAIT -> o_dbus_cyc high 6 cycles, o_rf_wreq on ack cycle only.
REQ-037 N_EXT=2, i_ext_op=2'b10, i_ext_ready=2'b01 then 2'b10 -> first ready ignored, wreq on second.
REQ-038 Macro defined, i_mem_misalign=1 on load -> no o_dbus_cyc, o_misalign_trap=1, o_rf_rreq pulse in WAIT.
REQ-039 i_rst_n low at INIT o_cnt=12 -> o_cnt=0, o_cnt_en=0 immediately, no wreq.
